// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, ALU operation codes
// and the operand forward-select encoding.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int SHAMT_WIDTH    = 5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI = 4'b0000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'b0010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'b0011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'b0100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'b0101;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for the EX stage. EX/MEM has priority over MEM/WB;
// register 0 is never forwarded.
import mips_pkg::*;

module forward_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
    input  logic                      exm_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output fwd_sel_e                  fwd_a,
    output fwd_sel_e                  fwd_b
);

    logic exm_live;
    logic wb_live;

    assign exm_live = exm_reg_write && (exm_rd != {REG_ADDR_WIDTH{1'b0}});
    assign wb_live  = wb_reg_write  && (wb_rd  != {REG_ADDR_WIDTH{1'b0}});

    // Select source for each operand, newest producer first
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (exm_live && (exm_rd == rs_addr)) begin
            fwd_a = FWD_EXM;
        end else if (wb_live && (wb_rd == rs_addr)) begin
            fwd_a = FWD_WB;
        end else begin
            fwd_a = FWD_REG;
        end
        if (exm_live && (exm_rd == rt_addr)) begin
            fwd_b = FWD_EXM;
        end else if (wb_live && (wb_rd == rt_addr)) begin
            fwd_b = FWD_WB;
        end else begin
            fwd_b = FWD_REG;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with forwarding muxes into the ALU and load-use
// hazard detection (one bubble per hazard).
import mips_pkg::*;

module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic [DATA_WIDTH-1:0]     rs_data_i,
    input  logic [DATA_WIDTH-1:0]     rt_data_i,
    input  logic [DATA_WIDTH-1:0]     imm_ext_i,
    input  logic [4:0]                shamt_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rt_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [ALU_OP_WIDTH-1:0]   alu_op_i,
    input  logic                      alu_src_i,
    input  logic                      reg_dst_i,
    input  logic                      reg_write_i,
    input  logic                      mem_read_i,
    input  logic                      mem_write_i,
    input  logic                      mem_to_reg_i,
    input  logic                      exm_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
    input  logic [DATA_WIDTH-1:0]     exm_result_i,
    input  logic                      wb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_result_i,
    output logic [ALU_OP_WIDTH-1:0]   alu_operation_o,
    output logic [DATA_WIDTH-1:0]     a_o,
    output logic [DATA_WIDTH-1:0]     b_o,
    output logic [4:0]                shamt_o,
    output logic [DATA_WIDTH-1:0]     store_data_o,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_o,
    output logic                      reg_write_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic                      mem_to_reg_o,
    output logic                      valid_o,
    output logic                      load_use_o
);

    logic                      valid_q;
    logic                      reg_write_q;
    logic                      mem_read_q;
    logic                      mem_write_q;
    logic                      mem_to_reg_q;
    logic                      alu_src_q;
    logic [ALU_OP_WIDTH-1:0]   alu_op_q;
    logic [4:0]                shamt_q;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
    logic [REG_ADDR_WIDTH-1:0] write_reg_q;
    logic [DATA_WIDTH-1:0]     rs_data_q;
    logic [DATA_WIDTH-1:0]     rt_data_q;
    logic [DATA_WIDTH-1:0]     imm_q;

    logic                      load_use;
    logic                      bubble;
    fwd_sel_e                  fwd_a;
    fwd_sel_e                  fwd_b;
    logic [DATA_WIDTH-1:0]     fwd_rs;
    logic [DATA_WIDTH-1:0]     fwd_rt;

    assign load_use = valid_q && mem_read_q
                   && (write_reg_q != {REG_ADDR_WIDTH{1'b0}})
                   && valid_i
                   && ((write_reg_q == rs_addr_i) || (write_reg_q == rt_addr_i));

    // Flush outranks stall; a load-use bubble only goes in when not frozen.
    assign bubble = flush_i || (!stall_i && load_use);

    // Pipeline register: reset/bubble zero everything, stall holds, else load ID
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= {ALU_OP_WIDTH{1'b0}};
            shamt_q      <= 5'd0;
            rs_addr_q    <= {REG_ADDR_WIDTH{1'b0}};
            rt_addr_q    <= {REG_ADDR_WIDTH{1'b0}};
            write_reg_q  <= {REG_ADDR_WIDTH{1'b0}};
            rs_data_q    <= {DATA_WIDTH{1'b0}};
            rt_data_q    <= {DATA_WIDTH{1'b0}};
            imm_q        <= {DATA_WIDTH{1'b0}};
        end else if (!stall_i) begin
            valid_q      <= valid_i;
            reg_write_q  <= reg_write_i;
            mem_read_q   <= mem_read_i;
            mem_write_q  <= mem_write_i;
            mem_to_reg_q <= mem_to_reg_i;
            alu_src_q    <= alu_src_i;
            alu_op_q     <= alu_op_i;
            shamt_q      <= shamt_i;
            rs_addr_q    <= rs_addr_i;
            rt_addr_q    <= rt_addr_i;
            write_reg_q  <= reg_dst_i ? rd_addr_i : rt_addr_i;
            rs_data_q    <= rs_data_i;
            rt_data_q    <= rt_data_i;
            imm_q        <= imm_ext_i;
        end
    end

    forward_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_forward_unit (
        .rs_addr       (rs_addr_q),
        .rt_addr       (rt_addr_q),
        .exm_reg_write (exm_reg_write_i),
        .exm_rd        (exm_rd_i),
        .wb_reg_write  (wb_reg_write_i),
        .wb_rd         (wb_rd_i),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Forwarding muxes stay live during stall so operands track producers
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        case (fwd_a)
            FWD_EXM: fwd_rs = exm_result_i;
            FWD_WB:  fwd_rs = wb_result_i;
            default: fwd_rs = rs_data_q;
        endcase
        case (fwd_b)
            FWD_EXM: fwd_rt = exm_result_i;
            FWD_WB:  fwd_rt = wb_result_i;
            default: fwd_rt = rt_data_q;
        endcase
    end

    assign a_o          = fwd_rs;
    assign b_o          = alu_src_q ? imm_q : fwd_rt;
    assign store_data_o = fwd_rt;
    assign load_use_o   = load_use;

    assign alu_operation_o = alu_op_q;
    assign shamt_o         = shamt_q;
    assign write_reg_o     = write_reg_q;
    assign reg_write_o     = reg_write_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_to_reg_o    = mem_to_reg_q;
    assign valid_o         = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: reset, ALU operand
// capture, forwarding priority, load-use bubble, stall and flush.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, stall_i, flush_i, valid_i;
    logic [31:0] rs_data_i, rt_data_i, imm_ext_i;
    logic [4:0]  shamt_i, rs_addr_i, rt_addr_i, rd_addr_i;
    logic [3:0]  alu_op_i;
    logic        alu_src_i, reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic        exm_reg_write_i, wb_reg_write_i;
    logic [4:0]  exm_rd_i, wb_rd_i;
    logic [31:0] exm_result_i, wb_result_i;
    logic [3:0]  alu_operation_o;
    logic [31:0] a_o, b_o, store_data_o;
    logic [4:0]  shamt_o, write_reg_o;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, load_use_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_ext_i(imm_ext_i), .shamt_i(shamt_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i),
        .exm_reg_write_i(exm_reg_write_i), .exm_rd_i(exm_rd_i), .exm_result_i(exm_result_i),
        .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
        .alu_operation_o(alu_operation_o), .a_o(a_o), .b_o(b_o), .shamt_o(shamt_o),
        .store_data_o(store_data_o), .write_reg_o(write_reg_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o), .load_use_o(load_use_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                             input logic [3:0] op, input logic src, input logic dst);
        valid_i   = 1'b1;
        rs_addr_i = rs;  rt_addr_i = rt;  rd_addr_i = rd;
        rs_data_i = rsd; rt_data_i = rtd; imm_ext_i = imm;
        alu_op_i  = op;  alu_src_i = src; reg_dst_i = dst;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        set_instr(5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 4'b0011, 1'b0, 1'b1);
        shamt_i = 5'd9; reg_write_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; mem_to_reg_i = 1'b0;
        exm_reg_write_i = 1'b0; exm_rd_i = 5'd0; exm_result_i = 32'h0;
        wb_reg_write_i = 1'b0;  wb_rd_i = 5'd0;  wb_result_i = 32'h0;

        // Reset held three cycles with a live instruction at ID
        repeat (3) tick();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_reg_write", {31'd0, reg_write_o}, 32'd0);
        check("rst_alu_op", {28'd0, alu_operation_o}, 32'd0);
        check("rst_write_reg", {27'd0, write_reg_o}, 32'd0);
        check("rst_shamt", {27'd0, shamt_o}, 32'd0);
        check("rst_a", a_o, 32'd0);
        check("rst_b", b_o, 32'd0);
        check("rst_store", store_data_o, 32'd0);
        check("rst_load_use", {31'd0, load_use_o}, 32'd0);
        reset = 1'b0;

        // ADDI rt=6, rs=5
        set_instr(5'd5, 5'd6, 5'd0, 32'h10, 32'h99, 32'h4, 4'b0011, 1'b1, 1'b0);
        shamt_i = 5'd7;
        tick();
        check("addi_a", a_o, 32'h10);
        check("addi_b", b_o, 32'h4);
        check("addi_op", {28'd0, alu_operation_o}, 32'h3);
        check("addi_wreg", {27'd0, write_reg_o}, 32'd6);
        check("addi_shamt", {27'd0, shamt_o}, 32'd7);
        check("addi_store", store_data_o, 32'h99);
        check("addi_valid", {31'd0, valid_o}, 32'd1);
        check("addi_regw", {31'd0, reg_write_o}, 32'd1);

        // Forwarding priority on rs=8
        set_instr(5'd8, 5'd3, 5'd12, 32'h5555, 32'h77, 32'h0, 4'b0101, 1'b0, 1'b1);
        tick();
        check("sub_wreg", {27'd0, write_reg_o}, 32'd12);
        exm_reg_write_i = 1'b1; exm_rd_i = 5'd8; exm_result_i = 32'hAAAA_0000;
        wb_reg_write_i  = 1'b1; wb_rd_i  = 5'd8; wb_result_i  = 32'h1234;
        #1;
        check("fwd_exm_wins", a_o, 32'hAAAA_0000);
        check("fwd_b_reg", b_o, 32'h77);
        exm_reg_write_i = 1'b0;
        #1;
        check("fwd_wb", a_o, 32'h1234);
        wb_reg_write_i = 1'b0;
        #1;
        check("fwd_none", a_o, 32'h5555);

        // Register 0 never forwarded
        set_instr(5'd0, 5'd7, 5'd0, 32'h42, 32'h66, 32'h8, 4'b0001, 1'b1, 1'b0);
        exm_reg_write_i = 1'b1; exm_rd_i = 5'd0; exm_result_i = 32'hBAD0_BAD0;
        wb_reg_write_i  = 1'b1; wb_rd_i  = 5'd0; wb_result_i  = 32'hBAD1_BAD1;
        tick();
        check("r0_no_fwd", a_o, 32'h42);
        check("r0_store", store_data_o, 32'h66);
        // rt forwarded to store data while B takes the immediate
        exm_rd_i = 5'd7; exm_result_i = 32'hCAFE_0007;
        #1;
        check("rt_fwd_store", store_data_o, 32'hCAFE_0007);
        check("rt_fwd_b_imm", b_o, 32'h8);
        exm_reg_write_i = 1'b0; wb_reg_write_i = 1'b0;

        // LW rt=9, then dependent ADD rs=9 -> load-use bubble
        set_instr(5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'h10, 4'b0011, 1'b1, 1'b0);
        mem_read_i = 1'b1; mem_to_reg_i = 1'b1;
        tick();
        set_instr(5'd9, 5'd2, 5'd10, 32'h0, 32'h3, 32'h0, 4'b0011, 1'b0, 1'b1);
        mem_read_i = 1'b0; mem_to_reg_i = 1'b0;
        #1;
        check("lw_load_use", {31'd0, load_use_o}, 32'd1);
        check("lw_mem_read", {31'd0, mem_read_o}, 32'd1);
        check("lw_wreg", {27'd0, write_reg_o}, 32'd9);
        tick();
        check("bubble_valid", {31'd0, valid_o}, 32'd0);
        check("bubble_mem_read", {31'd0, mem_read_o}, 32'd0);
        check("bubble_regw", {31'd0, reg_write_o}, 32'd0);
        check("bubble_load_use", {31'd0, load_use_o}, 32'd0);
        wb_reg_write_i = 1'b1; wb_rd_i = 5'd9; wb_result_i = 32'hDEAD;
        tick();
        check("dep_valid", {31'd0, valid_o}, 32'd1);
        check("dep_wreg", {27'd0, write_reg_o}, 32'd10);
        check("dep_a_wb", a_o, 32'hDEAD);
        check("dep_b", b_o, 32'h3);
        check("dep_load_use", {31'd0, load_use_o}, 32'd0);
        wb_reg_write_i = 1'b0;

        // Stall two cycles while EX/MEM result for rs=9 changes
        stall_i = 1'b1;
        exm_reg_write_i = 1'b1; exm_rd_i = 5'd9; exm_result_i = 32'h1;
        set_instr(5'd4, 5'd5, 5'd11, 32'h44, 32'h55, 32'h0, 4'b0010, 1'b0, 1'b1);
        tick();
        check("stall1_wreg", {27'd0, write_reg_o}, 32'd10);
        check("stall1_op", {28'd0, alu_operation_o}, 32'h3);
        check("stall1_a", a_o, 32'h1);
        exm_result_i = 32'h2;
        tick();
        check("stall2_wreg", {27'd0, write_reg_o}, 32'd10);
        check("stall2_a", a_o, 32'h2);
        check("stall2_valid", {31'd0, valid_o}, 32'd1);

        // Flush with stall and a valid SW at ID: bubble wins
        exm_reg_write_i = 1'b0;
        set_instr(5'd4, 5'd5, 5'd0, 32'h44, 32'h55, 32'hC, 4'b0011, 1'b1, 1'b0);
        reg_write_i = 1'b0; mem_write_i = 1'b1;
        flush_i = 1'b1;
        tick();
        check("flush_mem_write", {31'd0, mem_write_o}, 32'd0);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_wreg", {27'd0, write_reg_o}, 32'd0);
        flush_i = 1'b0; stall_i = 1'b0;
        tick();
        check("sw_mem_write", {31'd0, mem_write_o}, 32'd1);
        check("sw_valid", {31'd0, valid_o}, 32'd1);
        check("sw_store", store_data_o, 32'h55);
        check("sw_b", b_o, 32'hC);

        // LW to r0 never raises a hazard
        set_instr(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b1, 1'b0);
        mem_write_i = 1'b0; mem_read_i = 1'b1; reg_write_i = 1'b1;
        tick();
        set_instr(5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b0, 1'b1);
        mem_read_i = 1'b0;
        #1;
        check("lw_r0_no_hazard", {31'd0, load_use_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Captures decoded operands and control from ID, resolves EX/MEM and MEM/WB forwarding, and drives the ALU operand, shamt and operation inputs.
- Detects load-use hazards and inserts one bubble per detected hazard.
- Sits directly upstream of the ALU; the EX/MEM register consumes its memory/writeback control outputs.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, register index width
- ALU_OP_WIDTH, 4, ALU operation code width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall_i  input  1  external freeze; hold all registers
- flush_i  input  1  load bubble (branch/jump squash)
- valid_i  input  1  ID holds a real instruction
- rs_data_i, rt_data_i  input  DATA_WIDTH  register file read data
- imm_ext_i  input  DATA_WIDTH  sign/zero-extended immediate
- shamt_i  input  5  shift amount field
- rs_addr_i, rt_addr_i, rd_addr_i  input  REG_ADDR_WIDTH  register indices
- alu_op_i  input  ALU_OP_WIDTH  ALU operation code
- alu_src_i  input  1  1 = B operand is immediate
- reg_dst_i  input  1  1 = write rd, 0 = write rt
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  input  1 each  control
- exm_reg_write_i  input  1  EX/MEM writes a register
- exm_rd_i  input  REG_ADDR_WIDTH  EX/MEM destination
- exm_result_i  input  DATA_WIDTH  EX/MEM ALU result
- wb_reg_write_i  input  1  MEM/WB writes a register
- wb_rd_i  input  REG_ADDR_WIDTH  MEM/WB destination
- wb_result_i  input  DATA_WIDTH  MEM/WB writeback data
- alu_operation_o  output  ALU_OP_WIDTH  to ALU
- a_o, b_o  output  DATA_WIDTH  ALU operands (forwarded)
- shamt_o  output  5  to ALU
- store_data_o  output  DATA_WIDTH  forwarded rt for SW
- write_reg_o  output  REG_ADDR_WIDTH  destination index
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o  output  1 each  registered control
- load_use_o  output  1  combinational; freezes PC and IF/ID

Behaviour:
- Reset: all registered fields 0. Outputs valid_o=0, all control outputs 0, alu_operation_o=0, write_reg_o=0, shamt_o=0, a_o=b_o=store_data_o=0, load_use_o=0.
- Update priority on each rising edge: reset > flush_i > stall_i > load-use bubble > normal load.
- Bubble (flush or load-use): valid, reg_write, mem_read, mem_write and mem_to_reg cleared; data fields don't-care but driven to 0.
- Stall: every register holds its value. Forwarding muxes stay live, so operands track changing EX/MEM and MEM/WB values.
- Normal load: latches all ID inputs. write_reg = reg_dst_i ? rd_addr_i : rt_addr_i.
- load_use_o = valid_q & mem_read_q & (write_reg_q != 0) & valid_i & (write_reg_q == rs_addr_i | write_reg_q == rt_addr_i).
  - This register holds its previous contents and loads the bubble on the next edge.
  - Upstream holds ID, so the hazard deasserts one cycle later.
- Forwarding select, computed separately for the latched rs and rt:
  - EX/MEM if exm_reg_write_i, exm_rd_i != 0 and exm_rd_i matches.
  - Otherwise MEM/WB if wb_reg_write_i, wb_rd_i != 0 and wb_rd_i matches.
  - Otherwise the latched register data.
- EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- a_o = forwarded rs. b_o = alu_src_q ? imm_q : forwarded rt. store_data_o = forwarded rt, independent of alu_src.
- Operand outputs are combinational from registers and forwarding inputs (zero latency into the ALU). Control outputs are direct register outputs.
- Write-in-same-cycle between WB and ID is handled by the register file's write-through, not by this block.

Decomposition:
- Shared package mips_pkg:
  - ALU operation codes: ADD=0011, SUB=0101, LUI=0000, OR=0001, SLL=0010, SRL=0100.
  - Forward-select enum: FWD_REG, FWD_EXM, FWD_WB.
  - Width constants.
- One sub-module, forward_unit: purely combinational. Inputs are rs/rt indices and the EX/MEM and MEM/WB write info; outputs are two forward-select values. Instantiated once.

Test Plan:
- Reset then hold reset 3 cycles with valid_i=1, reg_write_i=1 -> all outputs 0, load_use_o=0.
- ADDI (rs=5, rs_data=0x10, imm=0x4, alu_src=1, alu_op=0011) -> next cycle a_o=0x10, b_o=0x4, alu_operation_o=0011, write_reg_o=rt.
- Latched rs=8; exm rd=8 result 0xAAAA_0000; wb rd=8 result 0x1234 -> a_o=0xAAAA_0000. Drop exm_reg_write_i -> a_o=0x1234. Set exm_rd_i=0 with rs=0 -> a_o=rs_data.
- LW (mem_read=1, rt=9) latched, ID presents rs_addr_i=9 -> load_use_o=1. Next cycle valid_o=0, mem_read_o=0, load_use_o=0. Following cycle the dependent instruction loads; wb forwarding supplies its operand.
- stall_i=1 for 2 cycles while exm_result_i changes 0x1→0x2 with matching rd -> registered fields unchanged, a_o follows 0x1 then 0x2.
- flush_i=1 together with stall_i=1 and a valid SW instruction -> bubble loaded: mem_write_o=0, valid_o=0.
